// File: rtl/mac_pair_accumulator.sv
// Dot-product stream stage: multiplies packed signed 16-bit operand pairs,
// accumulates a programmed number of products, emits one shifted, saturated result.
module mac_pair_accumulator #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 48,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    len_i,
    input  logic [4:0]              shift_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [DATA_WIDTH-1:0]   a_data_i,
    input  logic [DATA_WIDTH/8-1:0] a_strb_i,
    output logic                    d_valid_o,
    input  logic                    d_ready_i,
    output logic [DATA_WIDTH-1:0]   d_data_o,
    output logic [DATA_WIDTH/8-1:0] d_strb_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    cnt_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_e;

    state_e                        state_q, state_d;
    logic [CNT_WIDTH-1:0]          len_q, len_d;
    logic [CNT_WIDTH-1:0]          cnt_q, cnt_d;
    logic [4:0]                    shift_q, shift_d;
    logic signed [31:0]            prod_q, prod_d;
    logic                          s1_vld_q, s1_vld_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [DATA_WIDTH-1:0]         res_q, res_d;
    logic                          done_q, done_d;

    logic signed [15:0]            op_a, op_b;
    logic                          a_hs;
    logic signed [ACC_WIDTH-1:0]   shifted;
    logic [ACC_WIDTH-DATA_WIDTH:0] shifted_hi;
    logic [DATA_WIDTH-1:0]         sat_res;

    assign a_ready_o = (state_q == RUN) && (cnt_q < len_q);
    assign a_hs      = a_valid_i && a_ready_o;
    assign d_valid_o = (state_q == OUT);
    assign d_data_o  = res_q;
    assign d_strb_o  = '1;
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign cnt_o     = cnt_q;

    // Operands whose two strobe bytes are not both set contribute zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (a_strb_i[1:0] == 2'b11) op_a = a_data_i[15:0];
        if (a_strb_i[3:2] == 2'b11) op_b = a_data_i[31:16];
    end

    // Saturate when the bits above the result's sign bit disagree with it.
    always_comb begin
        shifted    = acc_q >>> shift_q;
        shifted_hi = shifted[ACC_WIDTH-1:DATA_WIDTH-1];
        sat_res    = shifted[DATA_WIDTH-1:0];
        if (!((&shifted_hi) || !(|shifted_hi))) begin
            sat_res = shifted[ACC_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        res_d    = res_q;
        done_d   = 1'b0;
        s1_vld_d = a_hs;
        prod_d   = a_hs ? op_a * op_b : prod_q;
        acc_d    = s1_vld_q ? acc_q + {{(ACC_WIDTH-32){prod_q[31]}}, prod_q} : acc_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    len_d    = len_i;
                    shift_d  = shift_i;
                    cnt_d    = '0;
                    acc_d    = '0;
                    s1_vld_d = 1'b0;
                    if (len_i == '0) begin
                        res_d   = '0;
                        state_d = OUT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (a_hs) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Stage 2 settles one cycle after the last product leaves stage 1.
                if (!s1_vld_q) begin
                    res_d   = sat_res;
                    state_d = OUT;
                end
            end
            OUT: begin
                if (d_ready_i) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
            prod_q   <= '0;
            s1_vld_q <= 1'b0;
            acc_q    <= '0;
            res_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            prod_q   <= prod_d;
            s1_vld_q <= s1_vld_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            done_q   <= done_d;
        end
    end

endmodule

// File: tb/tb_mac_pair_accumulator.sv
// Directed bench for mac_pair_accumulator; every cycle is observed 1 time unit after the rising edge.
module tb_mac_pair_accumulator;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] len_i;
    logic [4:0]  shift_i;
    logic        a_valid_i;
    logic        a_ready_o;
    logic [31:0] a_data_i;
    logic [3:0]  a_strb_i;
    logic        d_valid_o;
    logic        d_ready_i;
    logic [31:0] d_data_o;
    logic [3:0]  d_strb_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    mac_pair_accumulator #(.DATA_WIDTH(32), .ACC_WIDTH(48), .CNT_WIDTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .shift_i(shift_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i), .a_strb_i(a_strb_i),
        .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o), .d_strb_o(d_strb_o),
        .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [15:0] len, input logic [4:0] sh);
        start_i = 1'b1;
        len_i   = len;
        shift_i = sh;
        tick();
        start_i = 1'b0;
        len_i   = 16'hFFFF;
        shift_i = 5'd31;
        check("busy_after_start", {31'd0, busy_o}, 32'd1);
    endtask

    task automatic send_beat(input logic signed [15:0] a, input logic signed [15:0] b,
                             input logic [3:0] strb);
        a_data_i  = {b, a};
        a_strb_i  = strb;
        a_valid_i = 1'b1;
        for (int i = 0; i < 20 && !a_ready_o; i++) tick();
        check("a_ready_wait", {31'd0, a_ready_o}, 32'd1);
        tick();
        a_valid_i = 1'b0;
        a_data_i  = 32'hDEAD_BEEF;
    endtask

    task automatic finish_job(input string tag, input logic [31:0] exp, input logic [15:0] exp_cnt);
        d_ready_i = 1'b1;
        for (int i = 0; i < 20 && !d_valid_o; i++) tick();
        check({tag, "_valid"}, {31'd0, d_valid_o}, 32'd1);
        check({tag, "_data"}, d_data_o, exp);
        tick();
        check({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_cnt"}, {16'd0, cnt_o}, {16'd0, exp_cnt});
        tick();
        check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; len_i = '0; shift_i = '0;
        a_valid_i = 1'b0; a_data_i = '0; a_strb_i = 4'hF; d_ready_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        check("rst_a_ready", {31'd0, a_ready_o}, 32'd0);
        check("rst_d_valid", {31'd0, d_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_d_data", d_data_o, 32'd0);
        check("rst_cnt", {16'd0, cnt_o}, 32'd0);
        check("rst_strb", {28'd0, d_strb_o}, 32'hF);

        // Basic sum: 2 + 12 - 30 - 56 = -72, with exact output latency.
        d_ready_i = 1'b1;
        start_job(16'd4, 5'd0);
        send_beat(16'sd1, 16'sd2, 4'hF);
        send_beat(16'sd3, 16'sd4, 4'hF);
        send_beat(-16'sd5, 16'sd6, 4'hF);
        send_beat(16'sd7, -16'sd8, 4'hF);
        check("basic_c1_valid", {31'd0, d_valid_o}, 32'd0);
        check("basic_c1_ready", {31'd0, a_ready_o}, 32'd0);
        tick();
        check("basic_c2_valid", {31'd0, d_valid_o}, 32'd0);
        tick();
        check("basic_c3_valid", {31'd0, d_valid_o}, 32'd1);
        check("basic_c3_data", d_data_o, 32'hFFFF_FFB8);
        check("basic_c3_strb", {28'd0, d_strb_o}, 32'hF);
        tick();
        check("basic_c4_done", {31'd0, done_o}, 32'd1);
        check("basic_c4_busy", {31'd0, busy_o}, 32'd0);
        check("basic_c4_valid", {31'd0, d_valid_o}, 32'd0);
        check("basic_cnt", {16'd0, cnt_o}, 32'd4);
        tick();
        check("basic_c5_done", {31'd0, done_o}, 32'd0);

        // Shift and saturation.
        start_job(16'd2, 5'd0);
        send_beat(16'sh7FFF, 16'sh7FFF, 4'hF);
        send_beat(16'sh7FFF, 16'sh7FFF, 4'hF);
        finish_job("sat_2x", 32'h7FFE_0002, 16'd2);
        start_job(16'd3, 5'd0);
        for (int i = 0; i < 3; i++) send_beat(16'sh7FFF, 16'sh7FFF, 4'hF);
        finish_job("sat_pos", 32'h7FFF_FFFF, 16'd3);
        start_job(16'd3, 5'd4);
        for (int i = 0; i < 3; i++) send_beat(16'sh7FFF, 16'sh7FFF, 4'hF);
        finish_job("shift4", 32'h0BFF_D000, 16'd3);
        start_job(16'd2, 5'd0);
        send_beat(16'sh8000, 16'sh7FFF, 4'hF);
        send_beat(16'sh8000, 16'sh7FFF, 4'hF);
        finish_job("neg_2x", 32'h8001_0000, 16'd2);

        // Back-pressure with input gaps: 1 + 4 + 9 = 14.
        d_ready_i = 1'b0;
        start_job(16'd3, 5'd0);
        for (int i = 1; i <= 3; i++) begin
            send_beat(16'(i), 16'(i), 4'hF);
            tick();
        end
        for (int i = 0; i < 20 && !d_valid_o; i++) tick();
        check("bp_valid_rise", {31'd0, d_valid_o}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_valid", {31'd0, d_valid_o}, 32'd1);
            check("bp_hold_data", d_data_o, 32'd14);
            check("bp_hold_done", {31'd0, done_o}, 32'd0);
            tick();
        end
        d_ready_i = 1'b1;
        check("bp_data", d_data_o, 32'd14);
        tick();
        check("bp_done", {31'd0, done_o}, 32'd1);
        check("bp_cnt", {16'd0, cnt_o}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("bp_single_beat", {31'd0, d_valid_o}, 32'd0);
            tick();
        end

        // Strobes: B masked on the first beat, so only 2*4 counts.
        start_job(16'd2, 5'd0);
        send_beat(16'sd3, 16'sd5, 4'h3);
        send_beat(16'sd2, 16'sd4, 4'hF);
        finish_job("strb", 32'd8, 16'd2);

        // Zero-length job.
        d_ready_i = 1'b0;
        start_job(16'd0, 5'd0);
        check("zl_valid", {31'd0, d_valid_o}, 32'd1);
        check("zl_data", d_data_o, 32'd0);
        check("zl_a_ready", {31'd0, a_ready_o}, 32'd0);
        tick();
        check("zl_a_ready_hold", {31'd0, a_ready_o}, 32'd0);
        check("zl_cnt", {16'd0, cnt_o}, 32'd0);
        finish_job("zl", 32'd0, 16'd0);

        // Start pulse during RUN is ignored.
        start_job(16'd2, 5'd0);
        send_beat(16'sd1, 16'sd1, 4'hF);
        start_i = 1'b1;
        len_i   = 16'd5;
        tick();
        start_i = 1'b0;
        send_beat(16'sd1, 16'sd1, 4'hF);
        a_valid_i = 1'b1;
        check("ign_a_ready", {31'd0, a_ready_o}, 32'd0);
        check("ign_cnt", {16'd0, cnt_o}, 32'd2);
        tick();
        a_valid_i = 1'b0;
        finish_job("ign", 32'd2, 16'd2);

        // Reset mid-job after 2 of 4 beats.
        d_ready_i = 1'b1;
        start_job(16'd4, 5'd0);
        send_beat(16'sd9, 16'sd9, 4'hF);
        send_beat(16'sd9, 16'sd9, 4'hF);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_busy", {31'd0, busy_o}, 32'd0);
        check("mrst_a_ready", {31'd0, a_ready_o}, 32'd0);
        check("mrst_cnt", {16'd0, cnt_o}, 32'd0);
        check("mrst_d_data", d_data_o, 32'd0);
        check("mrst_strb", {28'd0, d_strb_o}, 32'hF);
        for (int i = 0; i < 4; i++) begin
            check("mrst_no_valid", {31'd0, d_valid_o}, 32'd0);
            check("mrst_no_done", {31'd0, done_o}, 32'd0);
            tick();
        end
        start_job(16'd1, 5'd0);
        send_beat(16'sd2, 16'sd3, 4'hF);
        finish_job("post_rst", 32'd6, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
